// File: rtl/parser_chk_pkg.sv
// Shared types and helpers for the Ethernet parser protocol monitor.
// Error codes index both the per-channel fire vector and the sticky-flag slices.
package parser_chk_pkg;

  localparam int unsigned ERR_NUM   = 10;
  localparam int unsigned ERR_SLOTS = 16;

  typedef enum logic [3:0] {
    E_START_IN_FRAME = 4'd0,
    E_HDR_OUTSIDE    = 4'd1,
    E_HDR_DUP        = 4'd2,
    E_END_NO_START   = 4'd3,
    E_VALID_DROP     = 4'd4,
    E_TLAST_CHG      = 4'd5,
    E_META_NO_HDR    = 4'd6,
    E_META_OUT_FRAME = 4'd7,
    E_HDR_TIMEOUT    = 4'd8,
    E_FRAME_TOO_LONG = 4'd9
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } ch_state_e;

  // The counter must hold MAX_BEATS+1 so that "exceeds MAX_BEATS" is observable.
  function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
    return $clog2(max_beats + 2);
  endfunction

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/parser_chk_channel.sv
// Per-channel protocol checker: frame FSM, beat watchdogs and AXI-stream stall history.
// Produces this cycle's fire vector and a clean-frame-closed strobe (both combinational).
module parser_chk_channel
  import parser_chk_pkg::*;
#(
  parameter int unsigned HDR_TIMEOUT = 64,
  parameter int unsigned MAX_BEATS   = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tvalid_i,
  input  logic        tready_i,
  input  logic        tlast_i,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  input  logic        header_done_i,
  input  logic        meta_valid_i,
  output logic [15:0] fire_o,
  output logic        frame_ok_o
);

  localparam int unsigned   BW      = beat_cnt_w(MAX_BEATS);
  localparam logic [BW-1:0] CNT_SAT = BW'(MAX_BEATS + 1);

  ch_state_e     state_q, state_d;
  ch_state_e     st_eff, st_h;
  logic [BW-1:0] beat_cnt_q, cnt_eff;
  logic          to_fired_q, long_fired_q, clean_q;
  logic          to_base, long_base, clean_base;
  logic          prev_valid_q, prev_ready_q, prev_last_q;
  logic          beat;

  assign beat = tvalid_i & tready_i;

  // Same-cycle ordering: start is applied first, then header_done; meta and end see the result.
  always_comb begin
    st_eff     = frame_start_i ? HDR : state_q;
    st_h       = (header_done_i && st_eff == HDR) ? PAY : st_eff;
    to_base    = frame_start_i ? 1'b0 : to_fired_q;
    long_base  = frame_start_i ? 1'b0 : long_fired_q;
    clean_base = frame_start_i ? 1'b1 : clean_q;
    cnt_eff    = beat_cnt_q;
    if (frame_start_i)
      cnt_eff = beat ? BW'(1) : '0;
    else if (state_q != IDLE && beat && beat_cnt_q != CNT_SAT)
      cnt_eff = beat_cnt_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = st_h;
    if (frame_end_i) state_d = IDLE;
  end

  // A header_done on the same beat that crosses the limit still counts as in time.
  always_comb begin
    fire_o                   = '0;
    fire_o[E_START_IN_FRAME] = frame_start_i & (state_q != IDLE);
    fire_o[E_HDR_OUTSIDE]    = header_done_i & (st_eff == IDLE);
    fire_o[E_HDR_DUP]        = header_done_i & (st_eff == PAY);
    fire_o[E_END_NO_START]   = frame_end_i & (st_eff == IDLE);
    fire_o[E_VALID_DROP]     = prev_valid_q & ~prev_ready_q & ~tvalid_i;
    fire_o[E_TLAST_CHG]      = prev_valid_q & ~prev_ready_q & tvalid_i & (tlast_i ^ prev_last_q);
    fire_o[E_META_NO_HDR]    = meta_valid_i & (st_h == HDR);
    fire_o[E_META_OUT_FRAME] = meta_valid_i & (st_h == IDLE);
    fire_o[E_HDR_TIMEOUT]    = (st_h == HDR) & (32'(cnt_eff) > HDR_TIMEOUT) & ~to_base;
    fire_o[E_FRAME_TOO_LONG] = (st_eff != IDLE) & (32'(cnt_eff) > MAX_BEATS) & ~long_base;
    frame_ok_o               = frame_end_i & (st_eff != IDLE) & clean_base & ~(|fire_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      to_fired_q   <= 1'b0;
      long_fired_q <= 1'b0;
      clean_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_last_q  <= 1'b0;
    end else begin
      beat_cnt_q   <= cnt_eff;
      to_fired_q   <= to_base | fire_o[E_HDR_TIMEOUT];
      long_fired_q <= long_base | fire_o[E_FRAME_TOO_LONG];
      clean_q      <= clean_base & ~(|fire_o);
      prev_valid_q <= tvalid_i;
      prev_ready_q <= tready_i;
      prev_last_q  <= tlast_i;
    end
  end

endmodule

// File: rtl/parser_protocol_monitor.sv
// Multi-channel, non-fatal protocol monitor for the Ethernet parser array.
// Aggregates per-channel fire vectors into a prioritised report, sticky flags and counters.
module parser_protocol_monitor
  import parser_chk_pkg::*;
#(
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  HDR_TIMEOUT  = 64,
  parameter int unsigned  MAX_BEATS    = 2048,
  parameter int unsigned  CNT_WIDTH    = 16,
  parameter int unsigned  FATAL_ON_ERR = 0,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             s_tvalid,
  input  logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH-1:0]             s_tlast,
  input  logic [NUM_CH-1:0]             frame_start,
  input  logic [NUM_CH-1:0]             frame_end,
  input  logic [NUM_CH-1:0]             header_done,
  input  logic [NUM_CH-1:0]             meta_valid,
  input  logic                          err_clr,
  output logic                          err_valid,
  output logic [CH_W-1:0]               err_ch,
  output logic [3:0]                    err_code,
  output logic [NUM_CH*16-1:0]          err_sticky,
  output logic [NUM_CH*CNT_WIDTH-1:0]   err_count,
  output logic [NUM_CH-1:0]             frames_ok
);

  localparam int unsigned    SUM_W   = CNT_WIDTH + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [15:0]                fire [NUM_CH];
  logic [NUM_CH-1:0]          frame_ok_c;
  logic                       rpt_valid;
  logic [CH_W-1:0]            rpt_ch;
  logic [3:0]                 rpt_code;
  logic                       err_valid_q;
  logic [CH_W-1:0]            err_ch_q;
  logic [3:0]                 err_code_q;
  logic [NUM_CH-1:0]          frames_ok_q;
  logic [NUM_CH*16-1:0]       sticky_q, sticky_d;
  logic [NUM_CH*CNT_WIDTH-1:0] count_q, count_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    parser_chk_channel #(
      .HDR_TIMEOUT (HDR_TIMEOUT),
      .MAX_BEATS   (MAX_BEATS)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .tvalid_i      (s_tvalid[g]),
      .tready_i      (s_tready[g]),
      .tlast_i       (s_tlast[g]),
      .frame_start_i (frame_start[g]),
      .frame_end_i   (frame_end[g]),
      .header_done_i (header_done[g]),
      .meta_valid_i  (meta_valid[g]),
      .fire_o        (fire[g]),
      .frame_ok_o    (frame_ok_c[g])
    );
  end

  // Lowest channel wins; within it the descending scan leaves the lowest code.
  always_comb begin
    rpt_valid = 1'b0;
    rpt_ch    = '0;
    rpt_code  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!rpt_valid && (|fire[c])) begin
        rpt_valid = 1'b1;
        rpt_ch    = CH_W'(c);
        for (int unsigned k = ERR_NUM; k > 0; k--)
          if (fire[c][k-1]) rpt_code = 4'(k - 1);
      end
    end
  end

  // Clear is applied before this cycle's firings so new violations survive err_clr.
  always_comb begin
    logic [CNT_WIDTH-1:0] base;
    logic [SUM_W-1:0]     sum;
    sticky_d = '0;
    count_d  = '0;
    base     = '0;
    sum      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sticky_d[c*16 +: 16] = (err_clr ? 16'h0000 : sticky_q[c*16 +: 16]) | fire[c];
      base = err_clr ? '0 : count_q[c*CNT_WIDTH +: CNT_WIDTH];
      sum  = SUM_W'(base) + SUM_W'(popcnt16(fire[c]));
      count_d[c*CNT_WIDTH +: CNT_WIDTH] = (sum > CNT_MAX) ? '1 : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_code_q  <= '0;
      frames_ok_q <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
    end else begin
      err_valid_q <= rpt_valid;
      if (rpt_valid) begin
        err_ch_q   <= rpt_ch;
        err_code_q <= rpt_code;
      end
      frames_ok_q <= frame_ok_c;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_ch     = err_ch_q;
  assign err_code   = err_code_q;
  assign frames_ok  = frames_ok_q;
  assign err_sticky = sticky_q;
  assign err_count  = count_q;

`ifndef SYNTHESIS
  if (FATAL_ON_ERR != 0) begin : g_fatal
    always_ff @(posedge clk) begin
      if (rst_n && rpt_valid)
        $fatal(1, "parser_protocol_monitor: violation on channel %0d, code %0d", rpt_ch, rpt_code);
    end
  end
`endif

endmodule

// File: tb/tb_parser_protocol_monitor.sv
// Directed scoreboard bench for parser_protocol_monitor (4 channels, short watchdog limits).
module tb_parser_protocol_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tv, tr, tl, fs, fe, hd, mv;
  logic        clr;
  logic        err_valid;
  logic [1:0]  err_ch;
  logic [3:0]  err_code;
  logic [63:0] err_sticky;
  logic [63:0] err_count;
  logic [3:0]  frames_ok;

  typedef struct {
    bit          v;
    int unsigned ch;
    int unsigned code;
    logic [3:0]  fok;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned held_ch = 0;
  int unsigned held_code = 0;

  parser_protocol_monitor #(
    .NUM_CH       (4),
    .HDR_TIMEOUT  (4),
    .MAX_BEATS    (16),
    .CNT_WIDTH    (16),
    .FATAL_ON_ERR (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tvalid    (tv),
    .s_tready    (tr),
    .s_tlast     (tl),
    .frame_start (fs),
    .frame_end   (fe),
    .header_done (hd),
    .meta_valid  (mv),
    .err_clr     (clr),
    .err_valid   (err_valid),
    .err_ch      (err_ch),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .frames_ok   (frames_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Output report for the inputs applied before the last posedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("err_valid", 64'(err_valid), 64'(e.v));
      if (e.v) begin
        held_ch   = e.ch;
        held_code = e.code;
      end
      check("err_ch", 64'(err_ch), 64'(held_ch));
      check("err_code", 64'(err_code), 64'(held_code));
      check("frames_ok", 64'(frames_ok), 64'(e.fok));
    end
  end

  task automatic clr_in();
    tv = '0; tr = '0; tl = '0; fs = '0; fe = '0; hd = '0; mv = '0; clr = 1'b0;
  endtask

  task automatic step(input bit v, input int unsigned ch, input int unsigned code,
                      input logic [3:0] fok);
    exp_t e;
    e.v = v; e.ch = ch; e.code = code; e.fok = fok;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic clean_frame(input int unsigned c);
    for (int unsigned b = 1; b <= 10; b++) begin
      clr_in();
      tv[c] = 1'b1; tr[c] = 1'b1;
      if (b == 1) fs[c] = 1'b1;
      if (b == 3) begin hd[c] = 1'b1; mv[c] = 1'b1; end
      if (b == 10) begin fe[c] = 1'b1; tl[c] = 1'b1; end
      step(0, 0, 0, (b == 10) ? (4'b0001 << c) : 4'b0000);
    end
    clr_in();
    step(0, 0, 0, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_ch", 64'(err_ch), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_sticky", err_sticky, 64'd0);
    check("rst_count", err_count, 64'd0);
    check("rst_frames_ok", 64'(frames_ok), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Clean frame on ch0
    clean_frame(0);
    drain();
    check("clean_sticky", err_sticky, 64'd0);
    check("clean_count", err_count, 64'd0);

    // Ch2 double start
    clr_in(); fs[2] = 1'b1; step(0, 0, 0, 4'b0000);
    clr_in(); fs[2] = 1'b1; step(1, 2, 0, 4'b0000);
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("dblstart_sticky32", 64'(err_sticky[32]), 64'd1);
    check("dblstart_sticky_ch2", 64'(err_sticky[32 +: 16]), 64'h0001);
    check("dblstart_count_ch2", 64'(err_count[32 +: 16]), 64'd1);

    // Ch1 header timeout: 15 beats, header never arrives
    for (int unsigned b = 1; b <= 15; b++) begin
      clr_in();
      tv[1] = 1'b1; tr[1] = 1'b1;
      if (b == 1) fs[1] = 1'b1;
      if (b == 15) begin fe[1] = 1'b1; tl[1] = 1'b1; end
      step(b == 5, 1, 8, 4'b0000);
    end
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("timeout_sticky_ch1", 64'(err_sticky[16 +: 16]), 64'h0100);
    check("timeout_count_ch1", 64'(err_count[16 +: 16]), 64'd1);

    // Ch0 code 3 and ch3 code 7 in the same cycle
    clr_in(); fe[0] = 1'b1; mv[3] = 1'b1; step(1, 0, 3, 4'b0000);
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("prio_sticky_ch3", 64'(err_sticky[48 +: 16]), 64'h0080);
    check("prio_count_ch3", 64'(err_count[48 +: 16]), 64'd1);
    check("prio_count_ch0", 64'(err_count[0 +: 16]), 64'd1);

    // Ch1 tlast toggled while stalled
    clr_in(); tv[1] = 1'b1; step(0, 0, 0, 4'b0000);
    clr_in(); tv[1] = 1'b1; tl[1] = 1'b1; step(1, 1, 5, 4'b0000);
    clr_in(); tv[1] = 1'b1; tr[1] = 1'b1; tl[1] = 1'b1; step(0, 0, 0, 4'b0000);
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("tlast_sticky_ch1", 64'(err_sticky[16 +: 16]), 64'h0120);
    check("tlast_count_ch1", 64'(err_count[16 +: 16]), 64'd2);
    clr_in(); clr = 1'b1; step(0, 0, 0, 4'b0000);
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("clr_sticky", err_sticky, 64'd0);
    check("clr_count", err_count, 64'd0);

    // Ch3 frame too long: 20 beats with MAX_BEATS=16
    for (int unsigned b = 1; b <= 20; b++) begin
      clr_in();
      tv[3] = 1'b1; tr[3] = 1'b1;
      if (b == 1) begin fs[3] = 1'b1; hd[3] = 1'b1; end
      if (b == 20) begin fe[3] = 1'b1; tl[3] = 1'b1; end
      step(b == 17, 3, 9, 4'b0000);
    end
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("long_sticky_ch3", 64'(err_sticky[48 +: 16]), 64'h0200);
    check("long_count_ch3", 64'(err_count[48 +: 16]), 64'd1);

    // Violation coinciding with err_clr survives the clear
    clr_in(); clr = 1'b1; fe[0] = 1'b1; step(1, 0, 3, 4'b0000);
    clr_in(); step(0, 0, 0, 4'b0000);
    drain();
    check("clrwin_sticky", err_sticky, 64'h0000_0000_0000_0008);
    check("clrwin_count", err_count, 64'h0000_0000_0000_0001);

    // Asynchronous reset mid-frame on ch0, then a clean frame
    clr_in(); tv[0] = 1'b1; tr[0] = 1'b1; fs[0] = 1'b1; step(0, 0, 0, 4'b0000);
    clr_in(); tv[0] = 1'b1; tr[0] = 1'b1; step(0, 0, 0, 4'b0000);
    drain();
    #1;
    rst_n = 1'b0;
    clr_in();
    held_ch = 0;
    held_code = 0;
    #1;
    check("arst_err_valid", 64'(err_valid), 64'd0);
    check("arst_err_code", 64'(err_code), 64'd0);
    check("arst_sticky", err_sticky, 64'd0);
    check("arst_count", err_count, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clean_frame(0);
    drain();
    check("post_rst_sticky", err_sticky, 64'd0);
    check("post_rst_count", err_count, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
